imem_dmem_arbiter: RTL and testbench

//  Sits directly downstream of the 5-stage processor's instruction-fetch and data-memory ports.

---
 rtl/imem_dmem_arbiter_pkg.sv | 25 ++
 rtl/imem_dmem_arbiter_if.sv | 41 ++++
 rtl/imem_dmem_arbiter_priority.sv | 29 ++
 rtl/imem_dmem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_dmem_arbiter_pkg.sv
// Types shared by the fetch/data memory arbiter, its priority select and its bus interface.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter; slave = arbiter view, master = environment view.
interface imem_dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mem_arb_pkg::*;

  logic [ADDR_W-1:0] if_addr;
  bus_cmd_t          if_command;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic [ADDR_W-1:0] d_addr;
  bus_cmd_t          d_command;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;

  logic [ADDR_W-1:0] mem_addr;
  bus_cmd_t          mem_command;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              err;

  modport slave (
    input  if_addr, if_command, d_addr, d_command, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
    output mem_addr, mem_command, mem_wdata, err
  );

  modport master (
    output if_addr, if_command, d_addr, d_command, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
    input  mem_addr, mem_command, mem_wdata, err
  );

endinterface

// File: rtl/imem_dmem_arbiter_priority.sv
// Grant select for the arbiter: data first, unless the waiting fetch has been starved long enough.
module arb_priority
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int SC_W         = 3
) (
  input  bus_cmd_t        if_command,
  input  bus_cmd_t        d_command,
  input  logic [SC_W-1:0] starve_cnt,
  input  logic            buf_hit,
  output logic            grant_d,
  output logic            grant_i,
  output logic            grant_hit
);

  logic fetch_req;
  logic force_i;

  always_comb begin
    fetch_req = (if_command == BUS_LOAD);
    force_i   = fetch_req && (starve_cnt == SC_W'(STARVE_LIMIT));
    grant_d   = (d_command != BUS_NONE) && !force_i;
    // a buffered fetch is only served when the data side is quiet
    grant_hit = fetch_req && (d_command == BUS_NONE) && buf_hit;
    grant_i   = fetch_req && !grant_d && !grant_hit;
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Merges fetch and data ports onto one variable-latency memory bus.
// IFETCH_BUF_EN adds a one-entry fetch buffer that can answer a repeated fetch without memory access.
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input logic                clk,
  input logic                rst,
  imem_dmem_arbiter_if.slave bus
);

  // state | meaning
  // IDLE  | no transaction; pick data, fetch or buffer hit
  // WAIT  | command on the memory bus, waiting for mem_ack or timeout
  // RESP  | one-cycle valid pulse to the owner, no new grant

  localparam int SC_W = cnt_w(STARVE_LIMIT + 1);
  localparam int WC_W = cnt_w(TIMEOUT);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  bus_cmd_t          mem_cmd_q, mem_cmd_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_valid_q, d_valid_d;
  logic              err_q, err_d;
  logic              grant_d, grant_i, grant_hit;
  logic              buf_match;

`ifdef IFETCH_BUF_EN
  logic [ADDR_W-1:0] buf_tag_q, buf_tag_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              buf_vld_q, buf_vld_d;
  assign buf_match = buf_vld_q && (buf_tag_q == bus.if_addr);
`else
  assign buf_match = 1'b0;
`endif

  arb_priority #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .SC_W        (SC_W)
  ) u_prio (
    .if_command(bus.if_command),
    .d_command (bus.d_command),
    .starve_cnt(starve_cnt_q),
    .buf_hit   (buf_match),
    .grant_d   (grant_d),
    .grant_i   (grant_i),
    .grant_hit (grant_hit)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    mem_addr_d   = mem_addr_q;
    mem_cmd_d    = mem_cmd_q;
    mem_wdata_d  = mem_wdata_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_valid_d   = 1'b0;
    d_valid_d    = 1'b0;
    err_d        = err_q;
`ifdef IFETCH_BUF_EN
    buf_tag_d    = buf_tag_q;
    buf_data_d   = buf_data_q;
    buf_vld_d    = buf_vld_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          owner_d     = OWN_D;
          mem_addr_d  = bus.d_addr;
          mem_cmd_d   = bus.d_command;
          mem_wdata_d = bus.d_wdata;
          wait_cnt_d  = '0;
          state_d     = WAIT;
          if (bus.if_command == BUS_LOAD && starve_cnt_q != STARVE_MAX)
            starve_cnt_d = starve_cnt_q + SC_W'(1);
`ifdef IFETCH_BUF_EN
          if (bus.d_command == BUS_STORE && bus.d_addr == buf_tag_q)
            buf_vld_d = 1'b0;
`endif
        end else if (grant_hit) begin
`ifdef IFETCH_BUF_EN
          if_rdata_d = buf_data_q;
`endif
          owner_d      = OWN_I;
          if_valid_d   = 1'b1;
          starve_cnt_d = '0;
          state_d      = RESP;
        end else if (grant_i) begin
          owner_d      = OWN_I;
          mem_addr_d   = bus.if_addr;
          mem_cmd_d    = BUS_LOAD;
          wait_cnt_d   = '0;
          starve_cnt_d = '0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_ack) begin
          mem_cmd_d = BUS_NONE;
          state_d   = RESP;
          if (owner_q == OWN_D) begin
            d_rdata_d = bus.mem_rdata;
            d_valid_d = 1'b1;
          end else begin
            if_rdata_d = bus.mem_rdata;
            if_valid_d = 1'b1;
`ifdef IFETCH_BUF_EN
            buf_tag_d  = mem_addr_q;
            buf_data_d = bus.mem_rdata;
            buf_vld_d  = 1'b1;
`endif
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          // timeout: complete the owner with zero data so the pipeline is not hung
          mem_cmd_d = BUS_NONE;
          state_d   = RESP;
          err_d     = 1'b1;
          if (owner_q == OWN_D) begin
            d_rdata_d = '0;
            d_valid_d = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_valid_d = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      mem_addr_q   <= '0;
      mem_cmd_q    <= BUS_NONE;
      mem_wdata_q  <= '0;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      if_rdata_q   <= '0;
      if_valid_q   <= 1'b0;
      d_rdata_q    <= '0;
      d_valid_q    <= 1'b0;
      err_q        <= 1'b0;
`ifdef IFETCH_BUF_EN
      buf_tag_q    <= '0;
      buf_data_q   <= '0;
      buf_vld_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      mem_addr_q   <= mem_addr_d;
      mem_cmd_q    <= mem_cmd_d;
      mem_wdata_q  <= mem_wdata_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      if_rdata_q   <= if_rdata_d;
      if_valid_q   <= if_valid_d;
      d_rdata_q    <= d_rdata_d;
      d_valid_q    <= d_valid_d;
      err_q        <= err_d;
`ifdef IFETCH_BUF_EN
      buf_tag_q    <= buf_tag_d;
      buf_data_q   <= buf_data_d;
      buf_vld_q    <= buf_vld_d;
`endif
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_command = mem_cmd_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.d_valid     = d_valid_q;
  assign bus.err         = err_q;
  assign bus.if_stall    = (bus.if_command == BUS_LOAD) && !if_valid_q;
  assign bus.d_stall     = (bus.d_command != BUS_NONE) && !d_valid_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: vector table, scoreboard on valid pulses, directed corner cases.
module tb_imem_dmem_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    bit          is_d;
    bus_cmd_t    cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    int          lat;
    bit          tmo;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    bit          chk;
  } sb_t;

  typedef struct {
    bus_cmd_t    cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } iss_t;

  logic clk;
  logic rst;
  imem_dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   mem_delay = 0;
  int   wait_ctr  = 0;
  bit   err_exp   = 0;
  sb_t  d_q[$];
  sb_t  i_q[$];
  iss_t issue_q[$];
  vec_t vecs[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hCAFEF00D;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // memory model: logs each issued command, acks after mem_delay WAIT cycles (-1 = never)
  always @(negedge clk) begin
    if (bus.mem_command != BUS_NONE) begin
      if (wait_ctr == 0) issue_q.push_back('{bus.mem_command, bus.mem_addr, bus.mem_wdata});
      if (mem_delay >= 0 && wait_ctr == mem_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_val(bus.mem_addr);
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hDEADBEEF;
      end
      wait_ctr++;
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'hDEADBEEF;
      wait_ctr      = 0;
    end
  end

  // scoreboard: every valid pulse must match the oldest expected result for that side
  always @(negedge clk) begin
    sb_t e;
    if (bus.d_valid) begin
      if (d_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL d_valid_unexpected actual=1 expected=0");
      end else begin
        e = d_q.pop_front();
        if (e.chk) chk("d_rdata", bus.d_rdata, e.data);
      end
    end
    if (bus.if_valid) begin
      if (i_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL if_valid_unexpected actual=1 expected=0");
      end else begin
        e = i_q.pop_front();
        if (e.chk) chk("if_rdata", bus.if_rdata, e.data);
      end
    end
  end

  task automatic do_txn(input string name, input bit is_d, input bus_cmd_t cmd,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int dly, input int exp_lat, input bit tmo, input bit exp_issue);
    int   base;
    int   lat;
    bit   seen;
    sb_t  e;
    iss_t s;
    base      = issue_q.size();
    mem_delay = dly;
    e.data    = tmo ? 32'h0 : mem_val(addr);
    e.chk     = (cmd == BUS_LOAD);
    if (is_d) begin
      d_q.push_back(e);
      bus.d_command = cmd; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      i_q.push_back(e);
      bus.if_command = cmd; bus.if_addr = addr;
    end
    #1;
    chk({name, "_stall_hi"}, is_d ? bus.d_stall : bus.if_stall, 1);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      seen = is_d ? bus.d_valid : bus.if_valid;
    end
    chk({name, "_seen"}, seen, 1);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_memcmd_resp"}, bus.mem_command, BUS_NONE);
    chk({name, "_stall_lo"}, is_d ? bus.d_stall : bus.if_stall, 0);
    if (is_d) bus.d_command = BUS_NONE;
    else      bus.if_command = BUS_NONE;
    if (exp_issue) begin
      chk({name, "_issued"}, issue_q.size(), base + 1);
      if (issue_q.size() > base) begin
        s = issue_q.pop_back();
        chk({name, "_iss_cmd"}, s.cmd, cmd);
        chk({name, "_iss_addr"}, s.addr, addr);
        if (cmd == BUS_STORE) chk({name, "_iss_wdata"}, s.wdata, wdata);
      end
    end else begin
      chk({name, "_no_issue"}, issue_q.size(), base);
    end
    @(negedge clk);
  endtask

  initial begin
    int base;
    int cyc;
    int d_lat;
    int i_lat;
    int dn;
    int stall_bad;
    bit d_done;
    bit i_done;
    logic [31:0] st_exp[6];

    vecs[0] = '{1'b1, BUS_LOAD,  32'h100, 32'h0,  0, 2,  1'b0};
    vecs[1] = '{1'b0, BUS_LOAD,  32'h040, 32'h0,  0, 2,  1'b0};
    vecs[2] = '{1'b1, BUS_STORE, 32'h200, 32'h11, 1, 3,  1'b0};
    vecs[3] = '{1'b0, BUS_LOAD,  32'h044, 32'h0,  3, 5,  1'b0};
    vecs[4] = '{1'b1, BUS_LOAD,  32'h104, 32'h0,  2, 4,  1'b0};
    vecs[5] = '{1'b1, BUS_LOAD,  32'h300, 32'h0, -1, 65, 1'b1};
    vecs[6] = '{1'b0, BUS_LOAD,  32'h048, 32'h0,  0, 2,  1'b0};
    vecs[7] = '{1'b1, BUS_LOAD,  32'h108, 32'h0, 63, 65, 1'b0};

    rst = 1'b0;
    bus.if_command = BUS_NONE; bus.if_addr = '0;
    bus.d_command  = BUS_NONE; bus.d_addr  = '0; bus.d_wdata = '0;
    bus.mem_ack    = 1'b0;     bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_memcmd", bus.mem_command, BUS_NONE);
    chk("rst_memaddr", bus.mem_addr, 0);
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_d_valid", bus.d_valid, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      do_txn($sformatf("vec%0d", v), vecs[v].is_d, vecs[v].cmd, vecs[v].addr, vecs[v].wdata,
             vecs[v].dly, vecs[v].lat, vecs[v].tmo, 1'b1);
      if (vecs[v].tmo) err_exp = 1'b1;
      chk($sformatf("vec%0d_err", v), bus.err, err_exp);
    end

    // simultaneous fetch and store: store first, fetch three cycles later
    base = issue_q.size();
    mem_delay = 0;
    d_q.push_back('{32'h0, 1'b0});
    i_q.push_back('{mem_val(32'h40), 1'b1});
    bus.d_command = BUS_STORE; bus.d_addr = 32'h200; bus.d_wdata = 32'h11;
    bus.if_command = BUS_LOAD; bus.if_addr = 32'h40;
    cyc = 0; d_done = 0; i_done = 0; stall_bad = 0; d_lat = 0; i_lat = 0;
    while (!(d_done && i_done) && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (!i_done && !bus.if_valid && !bus.if_stall) stall_bad++;
      if (bus.d_valid) begin d_lat = cyc; d_done = 1; bus.d_command = BUS_NONE; end
      if (bus.if_valid) begin i_lat = cyc; i_done = 1; bus.if_command = BUS_NONE; end
    end
    chk("sim_done", d_done && i_done, 1);
    chk("sim_d_lat", d_lat, 2);
    chk("sim_i_lat", i_lat, 5);
    chk("sim_if_stall", stall_bad, 0);
    chk("sim_issues", issue_q.size(), base + 2);
    if (issue_q.size() >= base + 2) begin
      chk("sim_first_cmd", issue_q[base].cmd, BUS_STORE);
      chk("sim_first_addr", issue_q[base].addr, 32'h200);
      chk("sim_second_addr", issue_q[base + 1].addr, 32'h40);
    end
    issue_q.delete();
    @(negedge clk);

    // starvation: continuous data loads, fetch 0x80 pending
    st_exp = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h080, 32'h410};
    mem_delay = 0;
    i_q.push_back('{mem_val(32'h80), 1'b1});
    d_q.push_back('{mem_val(32'h400), 1'b1});
    bus.if_command = BUS_LOAD; bus.if_addr = 32'h80;
    bus.d_command  = BUS_LOAD; bus.d_addr  = 32'h400;
    cyc = 0; dn = 0; i_done = 0;
    while ((dn < 5 || !i_done) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.d_valid) begin
        dn++;
        if (dn < 5) begin
          bus.d_addr = 32'h400 + 32'(4 * dn);
          d_q.push_back('{mem_val(bus.d_addr), 1'b1});
        end else begin
          bus.d_command = BUS_NONE;
        end
      end
      if (bus.if_valid) begin i_done = 1; bus.if_command = BUS_NONE; end
    end
    chk("starve_done", (dn == 5) && i_done, 1);
    chk("starve_issues", issue_q.size(), 6);
    if (issue_q.size() >= 6) begin
      for (int j = 0; j < 6; j++) chk($sformatf("starve_order%0d", j), issue_q[j].addr, st_exp[j]);
    end
    issue_q.delete();
    @(negedge clk);

    // reset while WAIT with err already set
    mem_delay = -1;
    bus.d_command = BUS_LOAD; bus.d_addr = 32'h500;
    repeat (2) @(negedge clk);
    chk("rstw_in_wait", bus.mem_command, BUS_LOAD);
    rst = 1'b0;
    #1;
    chk("rstw_memcmd", bus.mem_command, BUS_NONE);
    chk("rstw_d_valid", bus.d_valid, 0);
    chk("rstw_if_valid", bus.if_valid, 0);
    chk("rstw_err", bus.err, 0);
    bus.d_command = BUS_NONE;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rstw_issue", issue_q.size(), 1);
    issue_q.delete();
    @(negedge clk);
    do_txn("post_rst", 1'b0, BUS_LOAD, 32'h84, 32'h0, 0, 2, 1'b0, 1'b1);
    chk("post_rst_err", bus.err, 0);

`ifdef IFETCH_BUF_EN
    do_txn("buf_miss",  1'b0, BUS_LOAD,  32'h40, 32'h0,  0, 2, 1'b0, 1'b1);
    do_txn("buf_hit",   1'b0, BUS_LOAD,  32'h40, 32'h0,  0, 1, 1'b0, 1'b0);
    do_txn("buf_store", 1'b1, BUS_STORE, 32'h40, 32'h55, 0, 2, 1'b0, 1'b1);
    do_txn("buf_inval", 1'b0, BUS_LOAD,  32'h40, 32'h0,  0, 2, 1'b0, 1'b1);
`endif

    repeat (3) @(negedge clk);
    chk("sb_d_empty", d_q.size(), 0);
    chk("sb_i_empty", i_q.size(), 0);
    chk("issue_empty", issue_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
